// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with a run-time programmable inclusive
// limit, per-update step, wrap-or-saturate overflow policy and a registered
// terminal-count flag. Defining COUNTER_PRESCALE_EN adds an enable prescaler
// so that only every PRESCALE-th enabled cycle advances the count.
module mod_counter #(
   parameter int BITS     = 8,
   parameter int PRESCALE = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            inverseCounter,
   input  logic            load,
   input  logic [BITS-1:0] data,
   input  logic [BITS-1:0] step,
   input  logic [BITS-1:0] limit,
   input  logic            saturate,
   output logic [BITS-1:0] count,
   output logic            tc
);

   // One extra bit so limit = 2^BITS-1 and limit+1 never overflow.
   localparam int WW = BITS + 1;

   logic [BITS-1:0] count_q, count_d;
   logic            tc_q, tc_d;
   logic            advance;

   logic [WW-1:0]   count_w, limit_w, step_w, s_w;
   logic [WW-1:0]   sum_w, wrap_up_w, wrap_dn_w;
   logic            out_of_range, up_ovf, dn_unf;

`ifdef COUNTER_PRESCALE_EN
   // Prescaler is at least one bit wide so PRESCALE = 1 still elaborates;
   // in that case it stays at 0 and every enabled cycle is a tick.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;

   // Prescaler next state: cleared by load, wraps at PMAX, holds when idle.
   always_comb begin
      pre_d = pre_q;
      if (load)
         pre_d = '0;
      else if (enable)
         pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
   end

   assign advance = enable && (pre_q == PMAX);

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (reset)
         pre_q <= '0;
      else
         pre_q <= pre_d;
   end
`else
   assign advance = enable;
`endif

   assign count_w = {1'b0, count_q};
   assign limit_w = {1'b0, limit};
   assign step_w  = {1'b0, step};

   // Effective step is clamped to the limit so one update never crosses
   // more than one full period of the range.
   assign s_w          = (step_w > limit_w) ? limit_w : step_w;
   assign out_of_range = count_w > limit_w;
   assign sum_w        = count_w + s_w;
   assign up_ovf       = sum_w > limit_w;
   assign dn_unf       = count_w < s_w;
   assign wrap_up_w    = sum_w - (limit_w + 1'b1);
   assign wrap_dn_w    = count_w + limit_w + 1'b1 - s_w;

   // Next count/tc: load beats advance beats hold.
   always_comb begin
      count_d = count_q;
      tc_d    = tc_q;
      if (load) begin
         count_d = (data > limit) ? limit : data;
         tc_d    = 1'b0;
      end else if (advance) begin
         if (out_of_range) begin
            // Limit was lowered beneath the current count: snap back into range.
            count_d = saturate ? limit : '0;
            tc_d    = 1'b1;
         end else if (!inverseCounter) begin
            if (up_ovf) begin
               count_d = saturate ? limit : wrap_up_w[BITS-1:0];
               tc_d    = 1'b1;
            end else begin
               count_d = sum_w[BITS-1:0];
               tc_d    = 1'b0;
            end
         end else begin
            if (dn_unf) begin
               count_d = saturate ? '0 : wrap_dn_w[BITS-1:0];
               tc_d    = 1'b1;
            end else begin
               count_d = count_q - s_w[BITS-1:0];
               tc_d    = 1'b0;
            end
         end
      end
   end

   // Count and terminal-count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed testbench for mod_counter (BITS = 8). The prescaler scenario is
// compiled in only when COUNTER_PRESCALE_EN is defined.
module tb_mod_counter;

   localparam int BITS = 8;

   logic            clk;
   logic            reset;
   logic            enable;
   logic            inverseCounter;
   logic            load;
   logic [BITS-1:0] data;
   logic [BITS-1:0] step;
   logic [BITS-1:0] limit;
   logic            saturate;
   logic [BITS-1:0] count;
   logic            tc;

   int checks = 0;
   int errors = 0;

   mod_counter #(.BITS(BITS), .PRESCALE(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .inverseCounter (inverseCounter),
      .load           (load),
      .data           (data),
      .step           (step),
      .limit          (limit),
      .saturate       (saturate),
      .count          (count),
      .tc             (tc)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it and new
   // inputs are driven from there, well away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; enable = 1'b0; inverseCounter = 1'b0; load = 1'b0;
      data = '0; step = 8'd1; limit = 8'd255; saturate = 1'b0;
   endtask

   task automatic do_load(input logic [BITS-1:0] d, input logic [BITS-1:0] lim);
      load = 1'b1; enable = 1'b0; data = d; limit = lim;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if (count !== 8'd0 || tc !== 1'b0) begin
         errors++;
         $display("FAIL reset: count=%0d tc=%0b, required count=0 tc=0", count, tc);
      end
      reset = 1'b0;
   endtask

   task automatic test_up_wrap();
      logic [BITS-1:0] exp_c;
      logic            exp_t;
      idle_inputs();
      limit = 8'd9; step = 8'd1; reset = 1'b1; enable = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         tick();
         exp_c = 8'(i % 10);
         exp_t = (i == 10);
         checks++;
         if (count !== exp_c || tc !== exp_t) begin
            errors++;
            $display("FAIL up_wrap[%0d]: count=%0d tc=%0b, required count=%0d tc=%0b",
                     i, count, tc, exp_c, exp_t);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_down_saturate();
      logic [BITS-1:0] exp_c;
      idle_inputs();
      step = 8'd3; inverseCounter = 1'b1; saturate = 1'b1;
      do_load(8'd55, 8'd255);
      checks++;
      if (count !== 8'd55 || tc !== 1'b0) begin
         errors++;
         $display("FAIL down_sat_load: count=%0d tc=%0b, required count=55 tc=0", count, tc);
      end
      enable = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         exp_c = 8'(55 - 3 * k);
         checks++;
         if (count !== exp_c || tc !== 1'b0) begin
            errors++;
            $display("FAIL down_sat[%0d]: count=%0d tc=%0b, required count=%0d tc=0",
                     k, count, tc, exp_c);
         end
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (count !== 8'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL down_sat_pinned[%0d]: count=%0d tc=%0b, required count=0 tc=1",
                     k, count, tc);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_wraps();
      idle_inputs();
      // Down wrap: 2 - 5 in 0..9 gives 7.
      step = 8'd5; inverseCounter = 1'b1;
      do_load(8'd2, 8'd9);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      checks++;
      if (count !== 8'd7 || tc !== 1'b1) begin
         errors++;
         $display("FAIL down_wrap: count=%0d tc=%0b, required count=7 tc=1", count, tc);
      end
      // Full-range up wrap: 250 + 10 in 0..255 gives 4.
      step = 8'd10; inverseCounter = 1'b0;
      do_load(8'd250, 8'd255);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      checks++;
      if (count !== 8'd4 || tc !== 1'b1) begin
         errors++;
         $display("FAIL full_up_wrap: count=%0d tc=%0b, required count=4 tc=1", count, tc);
      end
      // Hold: nothing enabled, count and tc keep their values.
      tick(); tick();
      checks++;
      if (count !== 8'd4 || tc !== 1'b1) begin
         errors++;
         $display("FAIL hold: count=%0d tc=%0b, required count=4 tc=1", count, tc);
      end
   endtask

   task automatic test_load_rules();
      idle_inputs();
      // Load clamps to limit and clears tc (tc is 1 from the previous test).
      do_load(8'd200, 8'd100);
      checks++;
      if (count !== 8'd100 || tc !== 1'b0) begin
         errors++;
         $display("FAIL load_clamp: count=%0d tc=%0b, required count=100 tc=0", count, tc);
      end
      // Load wins over enable.
      limit = 8'd255; step = 8'd1; load = 1'b1; enable = 1'b1; data = 8'd55;
      tick();
      load = 1'b0;
      checks++;
      if (count !== 8'd55 || tc !== 1'b0) begin
         errors++;
         $display("FAIL load_vs_enable: count=%0d tc=%0b, required count=55 tc=0", count, tc);
      end
      // Step 0: advances leave the count alone.
      step = 8'd0; load = 1'b1; data = 8'd1;
      tick();
      load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (count !== 8'd1 || tc !== 1'b0) begin
            errors++;
            $display("FAIL step_zero[%0d]: count=%0d tc=%0b, required count=1 tc=0",
                     k, count, tc);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_limit_lowered();
      idle_inputs();
      step = 8'd1;
      do_load(8'd50, 8'd255);
      limit = 8'd20; saturate = 1'b0; enable = 1'b1;
      tick();
      enable = 1'b0;
      checks++;
      if (count !== 8'd0 || tc !== 1'b1) begin
         errors++;
         $display("FAIL lowered_wrap: count=%0d tc=%0b, required count=0 tc=1", count, tc);
      end
      do_load(8'd50, 8'd255);
      limit = 8'd20; saturate = 1'b1; inverseCounter = 1'b1; enable = 1'b1;
      tick();
      enable = 1'b0;
      checks++;
      if (count !== 8'd20 || tc !== 1'b1) begin
         errors++;
         $display("FAIL lowered_sat: count=%0d tc=%0b, required count=20 tc=1", count, tc);
      end
      // Reset beats a simultaneous load.
      reset = 1'b1; load = 1'b1; data = 8'd55; limit = 8'd255;
      tick();
      reset = 1'b0; load = 1'b0;
      checks++;
      if (count !== 8'd0 || tc !== 1'b0) begin
         errors++;
         $display("FAIL reset_vs_load: count=%0d tc=%0b, required count=0 tc=0", count, tc);
      end
   endtask

`ifdef COUNTER_PRESCALE_EN
   task automatic test_prescale();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0; enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (count !== ((k == 4) ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL prescale_run[%0d]: count=%0d, required %0d",
                     k, count, (k == 4) ? 1 : 0);
         end
      end
      // Two idle cycles push the next increment out by two cycles.
      enable = 1'b0;
      tick(); tick();
      enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (count !== ((k == 4) ? 8'd2 : 8'd1)) begin
            errors++;
            $display("FAIL prescale_gap[%0d]: count=%0d, required %0d",
                     k, count, (k == 4) ? 2 : 1);
         end
      end
      // Mid-phase load restarts the 4-cycle phase.
      tick(); tick();
      load = 1'b1; data = 8'd10;
      tick();
      load = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (count !== ((k == 4) ? 8'd11 : 8'd10)) begin
            errors++;
            $display("FAIL prescale_load[%0d]: count=%0d, required %0d",
                     k, count, (k == 4) ? 11 : 10);
         end
      end
      enable = 1'b0;
   endtask
`endif

   // Scenario sequence and final report.
   initial begin
      test_reset();
      test_up_wrap();
      test_down_saturate();
      test_wraps();
      test_load_rules();
      test_limit_lowered();
`ifdef COUNTER_PRESCALE_EN
      test_prescale();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
